serdiv_issuer: RTL and testbench

// Initiator side of the serdiv in/out handshake. Queues divide requests from an upstream issue stage,

---
 rtl/serdiv_pkg.sv | 30 +++
 rtl/serdiv_req_fifo.sv | 51 +++++
 rtl/serdiv_issuer.sv | 121 ++++++++++++
 tb/tb_serdiv_issuer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdiv_pkg.sv
// Shared types for the serdiv issuer: request payload, opcode encoding and issuer FSM states.
package serdiv_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned SERDIV_WIDTH  = 8;

  typedef enum logic [1:0] {
    UDIV = 2'd0,
    DIV  = 2'd1,
    UREM = 2'd2,
    REM  = 2'd3
  } serdiv_op_e;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [SERDIV_WIDTH-1:0]  op_a;
    logic [SERDIV_WIDTH-1:0]  op_b;
    serdiv_op_e               opcode;
    logic                     label_a;
    logic                     label_b;
  } serdiv_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } issuer_state_e;

endpackage

// File: rtl/serdiv_req_fifo.sv
// Synchronous request FIFO with flush; pointers wrap naturally because DEPTH is a power of two.
module serdiv_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = $clog2(DEPTH+1);

  T                    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q;
  logic [PTR_BITS-1:0] rd_ptr_q;
  logic                push_ok;
  logic                pop_ok;

  assign full_o  = (count_o == CNT_BITS'(DEPTH));
  assign empty_o = (count_o == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_o  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_o <= count_o + 1'b1;
      else if (pop_ok && !push_ok) count_o <= count_o - 1'b1;
    end
  end

endmodule

// File: rtl/serdiv_issuer.sv
// Initiator for the serdiv in/out handshake: queues requests, issues one at a time,
// registers each result into a writeback slot and bounds divider latency with a watchdog.
module serdiv_issuer
  import serdiv_pkg::*;
#(
  parameter int unsigned WIDTH   = SERDIV_WIDTH,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 2*WIDTH+8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_vld_i,
  output logic                     req_rdy_o,
  input  serdiv_req_t              req_i,
  output logic                     div_in_vld_o,
  input  logic                     div_in_rdy_i,
  output serdiv_req_t              div_req_o,
  output logic                     div_flush_o,
  input  logic                     div_out_vld_i,
  output logic                     div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0] div_id_i,
  input  logic [WIDTH-1:0]         div_res_i,
  input  logic                     div_label_res_i,
  output logic                     wb_vld_o,
  input  logic                     wb_rdy_i,
  output logic [TRANS_ID_BITS-1:0] wb_id_o,
  output logic [WIDTH-1:0]         wb_res_o,
  output logic                     wb_label_o,
  output logic                     wb_err_o,
  output logic                     busy_o
);
  localparam int unsigned WD_BITS  = $clog2(TIMEOUT+1);
  localparam int unsigned CNT_BITS = $clog2(DEPTH+1);

  issuer_state_e            state_q;
  logic [WD_BITS-1:0]       wd_q;
  logic [TRANS_ID_BITS-1:0] out_id_q;
  serdiv_req_t              head;
  logic                     full;
  logic                     empty;
  logic [CNT_BITS-1:0]      count;
  logic                     push;
  logic                     pop;
  logic                     timeout;

  assign push    = req_vld_i && req_rdy_o && !flush_i;
  assign pop     = (state_q == ISSUE) && div_in_rdy_i && !flush_i;
  assign timeout = (state_q == WAIT) && !div_out_vld_i && (wd_q == WD_BITS'(TIMEOUT-1));

  serdiv_req_fifo #(
    .DEPTH (DEPTH),
    .T     (serdiv_req_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (req_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign req_rdy_o     = !full;
  assign div_in_vld_o  = (state_q == ISSUE);
  assign div_req_o     = div_in_vld_o ? head : '0;
  assign div_out_rdy_o = (state_q == WAIT);
  assign wb_vld_o      = (state_q == WB);
  assign busy_o        = (count != '0) || (state_q != IDLE);
  // The serdiv has its own reset, so a flush request is suppressed while rst_i is high.
  assign div_flush_o   = !rst_i && (flush_i || timeout);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      wb_id_o    <= '0;
      wb_res_o   <= '0;
      wb_label_o <= 1'b0;
      wb_err_o   <= 1'b0;
      if (rst_i) out_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) state_q <= ISSUE;
        end
        ISSUE: begin
          if (div_in_rdy_i) begin
            out_id_q <= head.id;
            wd_q     <= '0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          wd_q <= wd_q + 1'b1;
          if (div_out_vld_i) begin
            wb_id_o    <= out_id_q;
            wb_res_o   <= div_res_i;
            wb_label_o <= div_label_res_i;
            wb_err_o   <= (div_id_i != out_id_q);
            state_q    <= WB;
          end else if (timeout) begin
            wb_id_o    <= out_id_q;
            wb_res_o   <= '0;
            wb_label_o <= 1'b1;
            wb_err_o   <= 1'b1;
            state_q    <= WB;
          end
        end
        WB: begin
          if (wb_rdy_i) state_q <= empty ? IDLE : ISSUE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serdiv_issuer.sv
// Directed bench for serdiv_issuer with a small behavioural divider responder attached.
module tb_serdiv_issuer;
  import serdiv_pkg::*;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     flush;
  logic                     req_vld;
  logic                     req_rdy;
  serdiv_req_t              req;
  logic                     div_in_vld;
  logic                     div_in_rdy;
  serdiv_req_t              div_req;
  logic                     div_flush;
  logic                     div_out_vld;
  logic                     div_out_rdy;
  logic [TRANS_ID_BITS-1:0] div_id;
  logic [WIDTH-1:0]         div_res;
  logic                     div_label_res;
  logic                     wb_vld;
  logic                     wb_rdy;
  logic [TRANS_ID_BITS-1:0] wb_id;
  logic [WIDTH-1:0]         wb_res;
  logic                     wb_label;
  logic                     wb_err;
  logic                     busy;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;   // 0 normal, 1 never responds, 2 returns wrong id
  logic hold   = 1'b0;

  serdiv_issuer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .req_vld_i       (req_vld),
    .req_rdy_o       (req_rdy),
    .req_i           (req),
    .div_in_vld_o    (div_in_vld),
    .div_in_rdy_i    (div_in_rdy),
    .div_req_o       (div_req),
    .div_flush_o     (div_flush),
    .div_out_vld_i   (div_out_vld),
    .div_out_rdy_o   (div_out_rdy),
    .div_id_i        (div_id),
    .div_res_i       (div_res),
    .div_label_res_i (div_label_res),
    .wb_vld_o        (wb_vld),
    .wb_rdy_i        (wb_rdy),
    .wb_id_o         (wb_id),
    .wb_res_o        (wb_res),
    .wb_label_o      (wb_label),
    .wb_err_o        (wb_err),
    .busy_o          (busy)
  );

  function automatic logic [7:0] div_model(input serdiv_req_t r);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    sa = r.op_a;
    sb = r.op_b;
    if (r.op_b == 8'd0) return (r.opcode == UDIV || r.opcode == DIV) ? 8'hFF : r.op_a;
    case (r.opcode)
      UDIV:    return r.op_a / r.op_b;
      UREM:    return r.op_a % r.op_b;
      DIV:     return 8'(sa / sb);
      default: return 8'(sa % sb);
    endcase
  endfunction

  logic        m_busy;
  logic        m_vld;
  int          m_cnt;
  serdiv_req_t m_req;

  always @(posedge clk) begin
    if (rst || div_flush) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
    end else if (!m_busy) begin
      if (div_in_vld && div_in_rdy) begin
        m_busy <= 1'b1;
        m_req  <= div_req;
        m_cnt  <= 3;
      end
    end else if (m_vld) begin
      if (div_out_rdy) begin
        m_vld  <= 1'b0;
        m_busy <= 1'b0;
      end
    end else if (m_cnt == 0) begin
      m_vld <= (mode != 1);
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign div_in_rdy    = !m_busy && !hold;
  assign div_out_vld   = m_vld;
  assign div_id        = (mode == 2) ? 3'd5 : m_req.id;
  assign div_res       = div_model(m_req);
  assign div_label_res = m_req.label_a | m_req.label_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic serdiv_req_t mk(input int id, input serdiv_op_e op, input logic [7:0] a,
                                     input logic [7:0] b, input logic la, input logic lb);
    serdiv_req_t r;
    r.id      = 3'(id);
    r.op_a    = a;
    r.op_b    = b;
    r.opcode  = op;
    r.label_a = la;
    r.label_b = lb;
    return r;
  endfunction

  task automatic push(input serdiv_req_t r);
    req     = r;
    req_vld = 1'b1;
    step();
    req_vld = 1'b0;
  endtask

  task automatic wait_wb(input string tag);
    int n = 0;
    while (!wb_vld && n < 100) begin
      step();
      n++;
    end
    if (!wb_vld) check_eq({tag, "_wb_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_in_wait(input string tag);
    int n = 0;
    while (!div_out_rdy && n < 100) begin
      step();
      n++;
    end
    if (!div_out_rdy) check_eq({tag, "_wait_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic ack_wb();
    wb_rdy = 1'b1;
    step();
    wb_rdy = 1'b0;
  endtask

  serdiv_req_t vec [4];
  logic [7:0]  exp_res [4];
  logic        exp_lab [4];

  initial begin
    int early;
    int nwb;
    logic [2:0] exp_id [3];

    rst = 1'b1; flush = 1'b0; req_vld = 1'b0; wb_rdy = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_req_rdy", 32'(req_rdy), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wb_vld", 32'(wb_vld), 32'd0);
    check_eq("rst_in_vld", 32'(div_in_vld), 32'd0);
    check_eq("rst_out_rdy", 32'(div_out_rdy), 32'd0);
    check_eq("rst_div_flush", 32'(div_flush), 32'd0);
    check_eq("rst_div_req", 32'(div_req), 32'd0);
    check_eq("rst_wb_payload", {wb_id, wb_res, wb_label, wb_err}, 32'd0);

    // single UDIV
    push(mk(3, UDIV, 8'd100, 8'd7, 1'b1, 1'b0));
    wait_wb("t1");
    check_eq("t1_id", 32'(wb_id), 32'd3);
    check_eq("t1_res", 32'(wb_res), 32'd14);
    check_eq("t1_label", 32'(wb_label), 32'd1);
    check_eq("t1_err", 32'(wb_err), 32'd0);
    step();
    check_eq("t1_wb_held", 32'(wb_vld), 32'd1);
    ack_wb();
    check_eq("t1_wb_drop", 32'(wb_vld), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // fill the queue while the divider refuses to accept
    vec[0] = mk(0, UDIV, 8'd50, 8'd5, 1'b0, 1'b0);   exp_res[0] = 8'h0A; exp_lab[0] = 1'b0;
    vec[1] = mk(1, UREM, 8'd50, 8'd7, 1'b1, 1'b0);   exp_res[1] = 8'h01; exp_lab[1] = 1'b1;
    vec[2] = mk(2, DIV,  8'hF9, 8'd2, 1'b0, 1'b1);   exp_res[2] = 8'hFD; exp_lab[2] = 1'b1;
    vec[3] = mk(3, REM,  8'hF9, 8'd2, 1'b0, 1'b0);   exp_res[3] = 8'hFF; exp_lab[3] = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fill_rdy%0d", i), 32'(req_rdy), 32'd1);
      req = vec[i];
      req_vld = 1'b1;
      step();
    end
    req = mk(7, UDIV, 8'd1, 8'd1, 1'b0, 1'b0);
    check_eq("full_rdy", 32'(req_rdy), 32'd0);
    step();
    req_vld = 1'b0;
    check_eq("full_count", 32'(dut.u_fifo.count_o), 32'd4);
    check_eq("issue_vld", 32'(div_in_vld), 32'd1);
    check_eq("issue_head", 32'(div_req), 32'(vec[0]));
    step();
    check_eq("issue_vld_held", 32'(div_in_vld), 32'd1);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_wb($sformatf("ord%0d", i));
      check_eq($sformatf("ord%0d_id", i), 32'(wb_id), 32'(vec[i].id));
      check_eq($sformatf("ord%0d_res", i), 32'(wb_res), 32'(exp_res[i]));
      check_eq($sformatf("ord%0d_lab", i), 32'(wb_label), 32'(exp_lab[i]));
      check_eq($sformatf("ord%0d_err", i), 32'(wb_err), 32'd0);
      ack_wb();
    end
    check_eq("ord_idle", 32'(busy), 32'd0);

    // push and pop in the same cycle at count 2
    hold = 1'b1;
    push(mk(4, UDIV, 8'd9, 8'd3, 1'b0, 1'b0));
    push(mk(5, UDIV, 8'd8, 8'd2, 1'b0, 1'b0));
    check_eq("pp_count_before", 32'(dut.u_fifo.count_o), 32'd2);
    hold = 1'b0;
    push(mk(6, UDIV, 8'd6, 8'd2, 1'b0, 1'b0));
    check_eq("pp_count", 32'(dut.u_fifo.count_o), 32'd2);
    check_eq("pp_wait", 32'(div_out_rdy), 32'd1);
    exp_id[0] = 3'd4; exp_id[1] = 3'd5; exp_id[2] = 3'd6;
    wb_rdy = 1'b1;
    nwb = 0;
    for (int n = 0; n < 200 && busy; n++) begin
      if (wb_vld) begin
        if (nwb < 3) check_eq($sformatf("pp_id%0d", nwb), 32'(wb_id), 32'(exp_id[nwb]));
        nwb++;
      end
      step();
    end
    wb_rdy = 1'b0;
    check_eq("pp_wb_count", 32'(nwb), 32'd3);

    // watchdog timeout
    mode = 1;
    push(mk(1, UDIV, 8'd10, 8'd2, 1'b0, 1'b0));
    wait_in_wait("to");
    early = 0;
    for (int k = 1; k < 24; k++) begin
      if (div_flush) early++;
      step();
    end
    check_eq("to_early_flush", 32'(early), 32'd0);
    check_eq("to_flush_pulse", 32'(div_flush), 32'd1);
    step();
    check_eq("to_flush_after", 32'(div_flush), 32'd0);
    check_eq("to_wb_vld", 32'(wb_vld), 32'd1);
    check_eq("to_id", 32'(wb_id), 32'd1);
    check_eq("to_err", 32'(wb_err), 32'd1);
    check_eq("to_res", 32'(wb_res), 32'd0);
    check_eq("to_label", 32'(wb_label), 32'd1);
    ack_wb();

    // id mismatch from the divider
    mode = 2;
    push(mk(2, UDIV, 8'd100, 8'd7, 1'b0, 1'b0));
    wait_wb("bad");
    check_eq("bad_id", 32'(wb_id), 32'd2);
    check_eq("bad_err", 32'(wb_err), 32'd1);
    check_eq("bad_res", 32'(wb_res), 32'd14);
    check_eq("bad_label", 32'(wb_label), 32'd0);
    ack_wb();

    // flush in WAIT with two queued, plus a push in the flush cycle
    mode = 1;
    push(mk(4, UDIV, 8'd4, 8'd2, 1'b0, 1'b0));
    wait_in_wait("fl");
    push(mk(5, UDIV, 8'd5, 8'd1, 1'b0, 1'b0));
    push(mk(6, UDIV, 8'd6, 8'd1, 1'b0, 1'b0));
    check_eq("fl_count", 32'(dut.u_fifo.count_o), 32'd2);
    flush = 1'b1;
    req = mk(7, UDIV, 8'd7, 8'd1, 1'b0, 1'b0);
    req_vld = 1'b1;
    #1;
    check_eq("fl_div_flush", 32'(div_flush), 32'd1);
    step();
    flush = 1'b0;
    req_vld = 1'b0;
    check_eq("fl_busy", 32'(busy), 32'd0);
    check_eq("fl_wb_vld", 32'(wb_vld), 32'd0);
    mode = 0;
    wb_rdy = 1'b1;
    nwb = 0;
    for (int n = 0; n < 40; n++) begin
      if (wb_vld) nwb++;
      step();
    end
    wb_rdy = 1'b0;
    check_eq("fl_no_wb", 32'(nwb), 32'd0);

    // reset mid-operation suppresses div_flush_o
    push(mk(1, UDIV, 8'd9, 8'd3, 1'b0, 1'b0));
    wait_in_wait("mr");
    rst = 1'b1;
    flush = 1'b1;
    #1;
    check_eq("mr_no_div_flush", 32'(div_flush), 32'd0);
    step();
    rst = 1'b0;
    flush = 1'b0;
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_req_rdy", 32'(req_rdy), 32'd1);
    check_eq("mr_out_rdy", 32'(div_out_rdy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
